pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
PWM receive-side block. It measures period and high time of an incoming asynchronous PWM line, counted in clk cycles. This is the counterpart of the team's 8-bit set/clear/reload PWM generator: a waveform from that generator with reload R, set S and clear C reads back as period R+1 and high time ((C-S) mod (R+1)). Results are published with a one-cycle valid strobe for a register bank or loopback checker.

Parameters:
CNT_W, 8, width of the cycle counter and of the result outputs; the largest measurable period is 2^CNT_W-1.
SYNC_STAGES, 2, number of flip-flops in the pwm_i synchronizer; legal values are 2 or more.

Ports:
clk  input  1  clock
res_ni  input  1  asynchronous active-low reset
pwm_i  input  1  asynchronous PWM line to be measured
en_i  input  1  capture enable, synchronous to clk
period_o  output  CNT_W  last measured period: clk cycles from one rising edge to the next
high_o  output  CNT_W  last measured high time: clk cycles from rising edge to falling edge
valid_o  output  1  one-cycle strobe; period_o and high_o updated this cycle
ovf_o  output  1  one-cycle strobe; counter saturated before the edge it was waiting for
busy_o  output  1  high when in state HIGH or LOW

Behaviour:
- Interface: one clock, clk. Reset res_ni is asynchronous and active-low.
- Reset values: all synchronizer flops, the previous-level flop, cnt, hi_cnt, period_o, high_o, valid_o and ovf_o are 0; state is IDLE.
- Input path:
  - pwm_i passes through SYNC_STAGES flops, giving the synchronized level s.
  - One further flop holds s_d, the previous value of s.
  - rise = s & ~s_d; fall = ~s & s_d. Both are combinational.
  - rise and fall can never occur in the same cycle.
- Latency: from pwm_i being sampled at a new level to the resulting state or valid_o update is SYNC_STAGES+1 clocks.
- State machine, with state and cnt both registered:
  - IDLE: cnt=0. If en_i=1, go to ARM. Any partial pulse already in progress is discarded.
  - ARM: wait for rise. On rise: cnt<=1 and go to HIGH.
  - HIGH: on fall, hi_cnt<=cnt, cnt<=cnt+1 and go to LOW. Otherwise cnt<=cnt+1.
  - LOW: on rise, period_o<=cnt, high_o<=hi_cnt, valid_o<=1 for exactly one cycle, cnt<=1 and go to HIGH (back-to-back measurements, no dead cycle). Otherwise cnt<=cnt+1.
- Result: for a rise detected at cycle t0, a fall at t1 and the next rise at t2, high_o = t1-t0 and period_o = t2-t0.
- Overflow:
  - Condition: in HIGH or LOW, cnt == 2^CNT_W-1 and the edge awaited in that state is absent this cycle.
  - Response: ovf_o=1 for one cycle, cnt<=0, go to ARM.
  - period_o and high_o are left unchanged.
  - This is the only detection path for a constant line (0 % or 100 % duty).
- en_i deasserted in any state: go to IDLE on the next clock and clear cnt. No valid_o or ovf_o is produced. period_o and high_o hold their values.
- Reset asserted mid-measurement: every register returns to its reset value immediately. No strobe fires while reset is held or on release.
- Arithmetic: cnt is unsigned CNT_W-bit and never wraps, because the overflow rule fires first. A pulse with a single synchronized high cycle gives high_o=1.
- Outputs are registered only; there is no combinational path from pwm_i to any output.

Test Plan:
- Generator loopback with reload=9, set=2, clear=6, en_i=1 -> first valid_o after one full period; every subsequent valid_o shows period_o=10 and high_o=4, spaced exactly 10 clocks apart.
- pwm_i drives a 1-cycle high pulse every 5 clocks -> period_o=5, high_o=1, valid_o every 5 clocks.
- pwm_i held high for 300 clocks after a rise (CNT_W=8) -> ovf_o pulses once, 255 clocks after the rise is detected; state returns to ARM; period_o and high_o keep their prior values; no valid_o.
- Period of exactly 255 (high 100, low 155) -> valid_o with period_o=255 and high_o=100; no ovf_o.
- en_i dropped in the middle of the LOW phase, then raised again -> no strobe; the first new valid_o comes only after ARM sees a rise followed by one full period.
- res_ni pulsed low while in HIGH -> all outputs read 0 immediately; after release, the next valid result follows ARM and one complete period.

Source files
------------

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period and high time of an asynchronous PWM line in clk cycles
module pwm_capture #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             res_ni,
  input  logic             pwm_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hi_cnt;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_valid;
  logic                   r_ovf;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_cnt_max;
  logic [CNT_W-1:0]       w_cnt_inc;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_d;
  assign w_fall    = ~w_s & r_s_d;
  assign w_cnt_max = (r_cnt == CNT_MAX);
  // Saturate so a fall exactly at the limit cannot wrap the count entering LOW.
  assign w_cnt_inc = w_cnt_max ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge res_ni) begin
    if (!res_ni) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_i};
      r_s_d  <= w_s;
    end
  end

  always_ff @(posedge clk or negedge res_ni) begin
    if (!res_ni) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hi_cnt <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      if (!en_i) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt   <= '0;
            r_state <= ARM;
          end
          ARM: begin
            if (w_rise) begin
              r_cnt   <= CNT_ONE;
              r_state <= HIGH;
            end
          end
          HIGH: begin
            if (w_fall) begin
              r_hi_cnt <= r_cnt;
              r_cnt    <= w_cnt_inc;
              r_state  <= LOW;
            end else if (w_cnt_max) begin
              r_ovf   <= 1'b1;
              r_cnt   <= '0;
              r_state <= ARM;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          LOW: begin
            if (w_rise) begin
              r_period <= r_cnt;
              r_high   <= r_hi_cnt;
              r_valid  <= 1'b1;
              r_cnt    <= CNT_ONE;
              r_state  <= HIGH;
            end else if (w_cnt_max) begin
              r_ovf   <= 1'b1;
              r_cnt   <= '0;
              r_state <= ARM;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign period_o = r_period;
  assign high_o   = r_high;
  assign valid_o  = r_valid;
  assign ovf_o    = r_ovf;
  assign busy_o   = (r_state == HIGH) || (r_state == LOW);

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized scoreboard bench for pwm_capture
module tb_pwm_capture;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int MAXC  = 255;

  logic             clk = 1'b0;
  logic             res_ni = 1'b0;
  logic             pwm_i = 1'b0;
  logic             en_i = 1'b0;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             ovf_o;
  logic             busy_o;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .res_ni(res_ni), .pwm_i(pwm_i), .en_i(en_i),
    .period_o(period_o), .high_o(high_o), .valid_o(valid_o),
    .ovf_o(ovf_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit is_ovf;
    int per;
    int hi;
  } ev_t;

  bit  lvl_q[$];
  bit  en_q[$];
  bit  rst_q[$];
  bit  cur_en = 1'b0;
  bit  cur_rst = 1'b1;
  ev_t exp_q[$];
  bit  busy_exp [0:8191];
  int  checks = 0;
  int  errors = 0;
  int  cur_cyc = -1;
  bit  running = 1'b0;
  int  n_cyc;

  int m_state = 0;  // 0 off, 1 armed, 2 high phase, 3 low phase
  int m_t0, m_t1;
  int m_per = 0;
  int m_hi = 0;

  task automatic add(input bit lv, input int n);
    for (int i = 0; i < n; i++) begin
      lvl_q.push_back(lv);
      en_q.push_back(cur_en);
      rst_q.push_back(cur_rst);
    end
  endtask

  function automatic bit rst_at(input int j);
    return (j < 0) ? 1'b1 : rst_q[j];
  endfunction

  // Synchronized level seen in cycle k: the line SYNC cycles earlier, unless reset flushed it.
  function automatic bit s_at(input int k);
    for (int j = k - SYNC; j < k; j++)
      if (rst_at(j)) return 1'b0;
    return lvl_q[k-SYNC];
  endfunction

  function automatic bit sd_at(input int k);
    return rst_at(k - 1) ? 1'b0 : s_at(k - 1);
  endfunction

  task automatic model_step(input int k);
    bit r, f, emit;
    r = s_at(k) & ~sd_at(k);
    f = ~s_at(k) & sd_at(k);
    emit = (k + 1 < n_cyc) && !rst_q[k+1];
    if (rst_q[k]) begin
      m_state = 0; m_per = 0; m_hi = 0;
    end else if (!en_q[k]) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: if (r) begin m_state = 2; m_t0 = k; end
        2: if (f) begin m_t1 = k; m_state = 3; end
           else if (k - m_t0 == MAXC) begin
             if (emit) exp_q.push_back('{k + 1, 1'b1, m_per, m_hi});
             m_state = 1;
           end
        default: if (r) begin
             m_per = k - m_t0; m_hi = m_t1 - m_t0;
             if (emit) exp_q.push_back('{k + 1, 1'b0, m_per, m_hi});
             m_t0 = k; m_state = 2;
           end else if (k - m_t0 == MAXC) begin
             if (emit) exp_q.push_back('{k + 1, 1'b1, m_per, m_hi});
             m_state = 1;
           end
      endcase
    end
    if (k + 1 < n_cyc)
      busy_exp[k+1] = (m_state >= 2) && !rst_q[k+1];
  endtask

  always @(negedge clk) begin
    if (running && cur_cyc >= 0) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cur_cyc) begin
        checks++; errors++;
        $display("FAIL missed_strobe cyc=%0d: no strobe seen, required ovf=%0b per=%0d hi=%0d",
                 exp_q[0].cyc, exp_q[0].is_ovf, exp_q[0].per, exp_q[0].hi);
        void'(exp_q.pop_front());
      end
      if (valid_o || ovf_o) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cur_cyc) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d: valid=%0b ovf=%0b per=%0d hi=%0d, required none",
                   cur_cyc, valid_o, ovf_o, period_o, high_o);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          if (valid_o != !ev.is_ovf || ovf_o != ev.is_ovf || period_o != ev.per || high_o != ev.hi) begin
            errors++;
            $display("FAIL strobe cyc=%0d: got valid=%0b ovf=%0b per=%0d hi=%0d, required valid=%0b ovf=%0b per=%0d hi=%0d",
                     cur_cyc, valid_o, ovf_o, period_o, high_o, !ev.is_ovf, ev.is_ovf, ev.per, ev.hi);
          end
        end
      end
      checks++;
      if (busy_o != busy_exp[cur_cyc]) begin
        errors++;
        $display("FAIL busy cyc=%0d: got %0b, required %0b", cur_cyc, busy_o, busy_exp[cur_cyc]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) busy_exp[i] = 1'b0;

    cur_rst = 1'b1; cur_en = 1'b0; add(0, 4);
    cur_rst = 1'b0; add(0, 2);
    cur_en = 1'b1;  add(0, 3);
    // generator loopback: reload 9, set 2, clear 6
    for (int p = 0; p < 8; p++)
      for (int c = 0; c <= 9; c++) add((c >= 2) && (c < 6), 1);
    add(0, 5);
    for (int p = 0; p < 8; p++) begin add(1, 1); add(0, 4); end
    // constant high line: overflow
    add(0, 20); add(1, 300); add(0, 20);
    // longest measurable period
    for (int p = 0; p < 3; p++) begin add(1, 100); add(0, 155); end
    add(1, 5); add(0, 10);
    // enable dropped during a low phase
    for (int p = 0; p < 4; p++) begin add(1, 4); add(0, 6); end
    add(1, 4); add(0, 3); cur_en = 1'b0; add(0, 2); cur_en = 1'b1; add(0, 1);
    for (int p = 0; p < 4; p++) begin add(1, 4); add(0, 6); end
    // reset pulsed while high
    add(1, 6); cur_rst = 1'b1; add(1, 3); cur_rst = 1'b0; add(1, 4); add(0, 5);
    for (int p = 0; p < 4; p++) begin add(1, 3); add(0, 5); end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) cur_en = 1'b0;
      add(1, $urandom_range(1, 40));
      add(0, $urandom_range(1, 40));
      cur_en = 1'b1;
    end
    add(0, 12);
    n_cyc = lvl_q.size();

    running = 1'b1;
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge clk);
      #1;
      pwm_i   = lvl_q[k];
      en_i    = en_q[k];
      res_ni  = !rst_q[k];
      cur_cyc = k;
      model_step(k);
      if (rst_q[k] && k >= 1 && (k == 1 || !rst_q[k-1])) begin
        #1;
        checks++;
        if (period_o != 0 || high_o != 0 || valid_o || ovf_o || busy_o) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d: per=%0d hi=%0d valid=%0b ovf=%0b busy=%0b, required all 0",
                   k, period_o, high_o, valid_o, ovf_o, busy_o);
        end
      end
    end
    @(negedge clk);
    running = 1'b0;
    #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_strobes: %0d left, required 0", exp_q.size());
    end
    checks++;
    if (period_o != m_per || high_o != m_hi) begin
      errors++;
      $display("FAIL final_result: per=%0d hi=%0d, required per=%0d hi=%0d", period_o, high_o, m_per, m_hi);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
